id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports (clock and reset first): clk in 1 (sole clock, all state updates on rising edge); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL have control ports: stall in 1 (hold stage); flush in 1 (squash); load_use_stall out 1 (hazard request to IF/ID).
REQ-003 SHALL have decode inputs: id_valid 1; id_rs1_data 32; id_rs2_data 32; id_imm 32; id_rs1 5; id_rs2 5; id_rd 5; id_alu_src 1 (1 = input2 from imm); id_ex_cmd 4; id_alu_op 2; id_reg_write 1; id_mem_read 1; id_mem_write 1.
REQ-004 SHALL have forwarding inputs: mem_rd 5; mem_reg_write 1; mem_alu_out 32; wb_rd 5; wb_reg_write 1; wb_data 32.
REQ-005 SHALL have outputs to ALU/EX: ex_valid 1; ex_input1 32; ex_input2 32; ex_cmd 4; ex_alu_op 2; ex_rd 5; ex_reg_write 1; ex_mem_read 1; ex_mem_write 1; ex_store_data 32; bubble_count 16.

Function
REQ-006 SHALL register all id_* fields plus id_valid into an ID/EX register; ex_cmd, ex_alu_op, ex_rd driven directly from it.
REQ-007 SHALL update the register each cycle by priority: rst > flush > stall > load_use_stall > normal capture.
REQ-008 flush: next state is a bubble (valid 0, all control 0, ex_cmd 4'b0000, ex_alu_op 2'd0, data fields 0), regardless of stall.
REQ-009 stall (no flush): all fields hold except stored rs1/rs2 data, which re-latch the forwarded operand values (REQ-012) so a producer retiring during the stall is not lost.
REQ-010 load_use_stall SHALL assert combinationally when stored valid=1, stored mem_read=1, stored rd!=0, id_valid=1, and (id_rs1==stored rd, or id_rs2==stored rd with id_alu_src=0 or id_mem_write=1).
REQ-011 load_use_stall with no stall/flush: capture a bubble (as REQ-008); upstream holds its instruction; next cycle the held instruction is captured normally.
REQ-012 Forwarding per operand (rsN): if mem_reg_write=1, mem_rd!=0, mem_rd==stored rsN -> mem_alu_out; else if wb_reg_write=1, wb_rd!=0, wb_rd==stored rsN -> wb_data; else stored rsN data. MEM takes priority over WB.
REQ-013 ex_input1 = forwarded rs1; ex_input2 = stored imm if stored alu_src=1, else forwarded rs2; ex_store_data = forwarded rs2 always. All combinational from register + forwarding inputs (zero added latency).
REQ-014 ex_reg_write, ex_mem_read, ex_mem_write SHALL be 0 whenever ex_valid=0.
REQ-015 Latency: ID fields captured at edge N appear on ex_* during cycle N+1.
REQ-016 bubble_count SHALL increment by 1 on each edge a bubble is inserted by REQ-011 (not flush), saturating at 16'hFFFF; held during stall.
REQ-017 Register x0 never forwarded; stored rsN=0 always yields stored data.

Reset
REQ-018 On rst=1 at an edge: register becomes bubble (ex_valid 0, all outputs 0, ex_alu_op 2'd0), bubble_count 0; rst overrides stall and flush.
REQ-019 load_use_stall SHALL be 0 during the cycle after reset (stored valid=0).

Verification
REQ-020 Normal: id rs1_data=5, rs2_data=3, alu_src=0, alu_op=2, ex_cmd=0001, rd=4, reg_write=1 -> next cycle ex_input1=5, ex_input2=3, ex_reg_write=1, ex_valid=1.
REQ-021 Forward priority: stored rs1=7, mem_rd=7 mem_alu_out=0x11, wb_rd=7 wb_data=0x22, both write=1 -> ex_input1=0x11; mem_reg_write=0 -> 0x22; mem_rd=wb_rd=0 with rs1=0 -> stored data.
REQ-022 Load-use: EX holds lw rd=3, ID presents add rs2=3 alu_src=0 -> load_use_stall=1, next cycle ex_valid=0, ex_reg_write=0, bubble_count=1; following cycle add captured, load_use_stall=0.
REQ-023 Stall refresh: stall=1 three cycles with stored rs1=2, wb_rd=2 wb_data=0x55 on cycle 1 only -> after stall release ex_input1=0x55, other fields unchanged.
REQ-024 Flush vs stall: flush=1 and stall=1 same edge with valid instruction stored -> next cycle ex_valid=0, ex_mem_write=0, bubble_count unchanged.
REQ-025 Reset mid-operation: rst=1 with stall=1 and valid store instruction -> next cycle all outputs 0, bubble_count=0; saturation: 65535 forced bubbles -> bubble_count stays 16'hFFFF after one more.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// The register holds one decoded instruction. The operand values that reach EX
// are chosen combinationally from the stored data and the MEM and WB results.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  output logic        load_use_stall,
  input  logic        id_valid,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_alu_src,
  input  logic [3:0]  id_ex_cmd,
  input  logic [1:0]  id_alu_op,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_alu_out,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_input1,
  output logic [31:0] ex_input2,
  output logic [3:0]  ex_cmd,
  output logic [1:0]  ex_alu_op,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic [15:0] bubble_count
);

  logic        valid_q;
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;
  logic [31:0] imm_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic        alu_src_q;
  logic [3:0]  cmd_q;
  logic [1:0]  alu_op_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [15:0] bubble_count_q;

  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic        insert_bubble;

  // Load-use hazard: a load in EX whose destination is read by the instruction in ID.
  // rs2 only matters if it is actually used as the ALU operand or as the store data.
  always_comb begin
    load_use_stall = 1'b0;
    if (valid_q && mem_read_q && (rd_q != 5'd0) && id_valid) begin
      load_use_stall = (id_rs1 == rd_q) ||
                       ((id_rs2 == rd_q) && (!id_alu_src || id_mem_write));
    end
  end

  // Operand forwarding: the younger MEM result beats WB, and x0 never forwards.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs1_q)) begin
      fwd_rs1 = mem_alu_out;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
      fwd_rs1 = wb_data;
    end
    fwd_rs2 = rs2_data_q;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs2_q)) begin
      fwd_rs2 = mem_alu_out;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
      fwd_rs2 = wb_data;
    end
  end

  // Flush always squashes. A load-use bubble is inserted only when the stage is not stalled.
  always_comb begin
    insert_bubble = flush || (!stall && load_use_stall);
  end

  // ID/EX register. While stalled it re-latches the forwarded operands, so a producer that
  // retires during the stall is still seen once the stall is released.
  always_ff @(posedge clk) begin
    if (rst || insert_bubble) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      alu_src_q   <= 1'b0;
      cmd_q       <= 4'b0000;
      alu_op_q    <= 2'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (stall) begin
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else begin
      valid_q     <= id_valid;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      alu_src_q   <= id_alu_src;
      cmd_q       <= id_ex_cmd;
      alu_op_q    <= id_alu_op;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

  // Saturating count of load-use bubbles. Flush bubbles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_q <= 16'd0;
    end else if (!flush && !stall && load_use_stall && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_q <= bubble_count_q + 16'd1;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_input1     = fwd_rs1;
  assign ex_input2     = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_cmd        = cmd_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q && reg_write_q;
  assign ex_mem_read   = valid_q && mem_read_q;
  assign ex_mem_write  = valid_q && mem_write_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the stage contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        load_use_stall;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_ex_cmd;
  logic [1:0]  id_alu_op;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_alu_out, wb_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_input1, ex_input2, ex_store_data;
  logic [3:0]  ex_cmd;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic [15:0] bubble_count;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .load_use_stall(load_use_stall),
    .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_ex_cmd(id_ex_cmd), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_out(mem_alu_out),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_input1(ex_input1), .ex_input2(ex_input2), .ex_cmd(ex_cmd),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  // Model of the instruction currently sitting between ID and EX
  typedef struct packed {
    logic        valid;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [3:0]  cmd;
    logic [1:0]  alu_op;
    logic        rw, mr, mw;
  } instr_t;

  instr_t      m = '0;
  logic [15:0] mcnt = 16'd0;

  wire logic [127:0] dut_vec = {ex_valid, ex_input1, ex_input2, ex_cmd, ex_alu_op, ex_rd,
                                ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
                                bubble_count, load_use_stall};

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
    if (rs == 5'd0) return d;
    if (mem_reg_write && mem_rd == rs) return mem_alu_out;
    if (wb_reg_write && wb_rd == rs) return wb_data;
    return d;
  endfunction

  function automatic logic model_luse();
    if (!(m.valid && m.mr && m.rd != 5'd0 && id_valid)) return 1'b0;
    if (id_rs1 == m.rd) return 1'b1;
    return (id_rs2 == m.rd) && (!id_alu_src || id_mem_write);
  endfunction

  function automatic logic [127:0] model_out();
    logic [31:0] a = fwd(m.rs1, m.rs1d);
    logic [31:0] b = fwd(m.rs2, m.rs2d);
    return {m.valid, a, (m.alu_src ? m.imm : b), m.cmd, m.alu_op, m.rd,
            m.valid & m.rw, m.valid & m.mr, m.valid & m.mw, b, mcnt, model_luse()};
  endfunction

  // One clock edge: the model advances from the inputs present before the edge
  task automatic tick();
    instr_t      nxt = m;
    logic [15:0] ncnt = mcnt;
    if (rst) begin
      nxt = '0; ncnt = 16'd0;
    end else if (flush) begin
      nxt = '0;
    end else if (stall) begin
      nxt.rs1d = fwd(m.rs1, m.rs1d);
      nxt.rs2d = fwd(m.rs2, m.rs2d);
    end else if (model_luse()) begin
      nxt = '0;
      if (ncnt != 16'hFFFF) ncnt = ncnt + 16'd1;
    end else begin
      nxt = {id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_src, id_ex_cmd, id_alu_op, id_reg_write, id_mem_read, id_mem_write};
    end
    @(posedge clk);
    m = nxt;
    mcnt = ncnt;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0;
    id_rd = 0; id_alu_src = 0; id_ex_cmd = 0; id_alu_op = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0;
    mem_rd = 0; mem_reg_write = 0; mem_alu_out = 0; wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 1; flush = 0;
    idle();
    tick(); tick();
    vectors++; if (dut_vec !== model_out()) begin miscompares++; $display("[TB] FAIL reset_outputs got %h want %h", dut_vec, model_out()); end
    vectors++; if (bubble_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_count got %h want 0", bubble_count); end
    rst = 0; stall = 0;
    id_valid = 1; id_rs1 = 0; id_rs2 = 0; #1;
    vectors++; if (load_use_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_luse got %b want 0", load_use_stall); end
    idle();
  endtask

  task automatic test_normal();
    idle();
    id_valid = 1; id_rs1_data = 5; id_rs2_data = 3; id_rs1 = 1; id_rs2 = 2; id_alu_src = 0;
    id_alu_op = 2; id_ex_cmd = 4'b0001; id_rd = 4; id_reg_write = 1;
    tick();
    idle();
    vectors++; if (ex_input1 !== 32'd5) begin miscompares++; $display("[TB] FAIL normal_in1 got %h want 5", ex_input1); end
    vectors++; if (ex_input2 !== 32'd3) begin miscompares++; $display("[TB] FAIL normal_in2 got %h want 3", ex_input2); end
    vectors++; if ({ex_valid, ex_reg_write, ex_cmd, ex_alu_op, ex_rd} !== {1'b1, 1'b1, 4'b0001, 2'd2, 5'd4}) begin
      miscompares++; $display("[TB] FAIL normal_ctrl got %b%b %h %h %h want 1 1 1 2 4", ex_valid, ex_reg_write, ex_cmd, ex_alu_op, ex_rd); end
    vectors++; if (dut_vec !== model_out()) begin miscompares++; $display("[TB] FAIL normal_model got %h want %h", dut_vec, model_out()); end
  endtask

  task automatic test_forward_priority();
    idle();
    id_valid = 1; id_rs1 = 7; id_rs1_data = 32'h99; id_rs2 = 7; id_rs2_data = 32'h98;
    id_alu_src = 1; id_imm = 32'h44; id_rd = 1; id_reg_write = 1;
    tick();
    id_valid = 0;
    mem_rd = 7; mem_alu_out = 32'h11; mem_reg_write = 1; wb_rd = 7; wb_data = 32'h22; wb_reg_write = 1; #1;
    vectors++; if (ex_input1 !== 32'h11) begin miscompares++; $display("[TB] FAIL fwd_mem got %h want 11", ex_input1); end
    vectors++; if ({ex_input2, ex_store_data} !== {32'h44, 32'h11}) begin miscompares++; $display("[TB] FAIL fwd_imm_store got %h %h want 44 11", ex_input2, ex_store_data); end
    mem_reg_write = 0; #1;
    vectors++; if (ex_input1 !== 32'h22) begin miscompares++; $display("[TB] FAIL fwd_wb got %h want 22", ex_input1); end
    mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1; #1;
    vectors++; if (ex_input1 !== 32'h99) begin miscompares++; $display("[TB] FAIL fwd_none got %h want 99", ex_input1); end
    id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h33;
    tick();
    vectors++; if (ex_input1 !== 32'h33) begin miscompares++; $display("[TB] FAIL fwd_x0 got %h want 33", ex_input1); end
    vectors++; if (dut_vec !== model_out()) begin miscompares++; $display("[TB] FAIL fwd_model got %h want %h", dut_vec, model_out()); end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; id_rd = 3; id_rs1 = 1; id_mem_read = 1; id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_rs2 = 3; id_alu_src = 1; id_rd = 6; id_reg_write = 1; #1;
    vectors++; if (load_use_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL luse_imm got %b want 0", load_use_stall); end
    id_mem_write = 1; #1;
    vectors++; if (load_use_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL luse_store got %b want 1", load_use_stall); end
    id_mem_write = 0; id_alu_src = 0; #1;
    vectors++; if (load_use_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL luse_rs2 got %b want 1", load_use_stall); end
    tick();
    vectors++; if ({ex_valid, ex_reg_write, bubble_count} !== {1'b0, 1'b0, 16'd1}) begin
      miscompares++; $display("[TB] FAIL luse_bubble got %b %b %0d want 0 0 1", ex_valid, ex_reg_write, bubble_count); end
    tick();
    vectors++; if ({ex_valid, ex_rd, load_use_stall} !== {1'b1, 5'd6, 1'b0}) begin
      miscompares++; $display("[TB] FAIL luse_capture got %b %0d %b want 1 6 0", ex_valid, ex_rd, load_use_stall); end
    vectors++; if (dut_vec !== model_out()) begin miscompares++; $display("[TB] FAIL luse_model got %h want %h", dut_vec, model_out()); end
    idle();
  endtask

  task automatic test_stall_refresh();
    idle();
    id_valid = 1; id_rs1 = 2; id_rs1_data = 32'h10; id_rs2 = 4; id_rs2_data = 32'h20;
    id_rd = 9; id_reg_write = 1; id_ex_cmd = 3;
    tick();
    idle();
    stall = 1; wb_rd = 2; wb_reg_write = 1; wb_data = 32'h55;
    tick();
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    tick(); tick();
    stall = 0; #1;
    vectors++; if (ex_input1 !== 32'h55) begin miscompares++; $display("[TB] FAIL stall_refresh got %h want 55", ex_input1); end
    vectors++; if ({ex_valid, ex_input2, ex_rd, ex_cmd, ex_reg_write} !== {1'b1, 32'h20, 5'd9, 4'd3, 1'b1}) begin
      miscompares++; $display("[TB] FAIL stall_hold got %b %h %0d %0d %b want 1 20 9 3 1", ex_valid, ex_input2, ex_rd, ex_cmd, ex_reg_write); end
    vectors++; if (dut_vec !== model_out()) begin miscompares++; $display("[TB] FAIL stall_model got %h want %h", dut_vec, model_out()); end
  endtask

  task automatic test_flush_vs_stall();
    idle();
    id_valid = 1; id_rd = 3; id_rs1 = 1; id_mem_read = 1; id_mem_write = 1;
    tick();
    idle();
    vectors++; if (ex_mem_write !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_pre got %b want 1", ex_mem_write); end
    id_valid = 1; id_rs1 = 3; flush = 1; stall = 1;
    tick();
    flush = 0; stall = 0;
    idle();
    vectors++; if ({ex_valid, ex_mem_write, bubble_count} !== {1'b0, 1'b0, 16'd1}) begin
      miscompares++; $display("[TB] FAIL flush_stall got %b %b %0d want 0 0 1", ex_valid, ex_mem_write, bubble_count); end
  endtask

  task automatic test_reset_mid();
    idle();
    id_valid = 1; id_rd = 3; id_rs1 = 1; id_mem_read = 1;
    tick();
    idle();
    id_valid = 1; id_rs1 = 3;
    tick();
    vectors++; if (bubble_count !== 16'd2) begin miscompares++; $display("[TB] FAIL rstmid_pre got %0d want 2", bubble_count); end
    id_valid = 1; id_rs1 = 5; id_rs1_data = 32'hAB; id_rd = 7; id_reg_write = 1; id_mem_write = 1; id_ex_cmd = 9; id_alu_op = 3;
    tick();
    idle();
    stall = 1; rst = 1;
    tick();
    rst = 0; stall = 0; #1;
    vectors++; if (dut_vec !== 128'd0) begin miscompares++; $display("[TB] FAIL rstmid_outputs got %h want 0", dut_vec); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_sat [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    idle();
    force dut.bubble_count_q = 16'hFFFD;
    #1;
    release dut.bubble_count_q;
    mcnt = 16'hFFFD;
    id_valid = 1; id_rd = 3; id_rs1 = 3; id_mem_read = 1; id_reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); tick();
      vectors++; if (bubble_count !== exp_sat[i]) begin miscompares++; $display("[TB] FAIL saturate_%0d got %h want %h", i, bubble_count, exp_sat[i]); end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0); stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 3) != 0); id_rs1_data = $urandom(); id_rs2_data = $urandom(); id_imm = $urandom();
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
      id_alu_src = ($urandom_range(0, 1) == 1); id_ex_cmd = 4'($urandom_range(0, 15)); id_alu_op = 2'($urandom_range(0, 3));
      id_reg_write = ($urandom_range(0, 1) == 1); id_mem_read = ($urandom_range(0, 1) == 1); id_mem_write = ($urandom_range(0, 2) == 0);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = ($urandom_range(0, 1) == 1); mem_alu_out = $urandom();
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = ($urandom_range(0, 1) == 1); wb_data = $urandom();
      #1;
      vectors++; if (dut_vec !== model_out()) begin miscompares++; $display("[TB] FAIL random_%0d got %h want %h", i, dut_vec, model_out()); end
      tick();
    end
    rst = 0; stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_forward_priority();
    test_load_use();
    test_stall_refresh();
    test_flush_vs_stall();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
